expression_datapath: RTL and testbench

Arithmetic datapath for the expression solver; sits directly downstream of the `control` FSM and executes the load, select and operation strobes it drives. Each cycle it holds three working registers (X, S, H) and a shared add/subtract ALU with a post-shift stage. When `completed` pulses, it captures S into an output register presented on a valid/ready handshake.

---
 rtl/expr_pkg.sv | 30 +++
 rtl/expr_alu.sv | 36 +++
 rtl/expression_datapath.sv | 117 +++++++++++
 tb/tb_expression_datapath.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared encodings and defaults for the expression solver datapath.
package expr_pkg;

   localparam int unsigned W_DEF = 16;

   localparam logic OP_ADD = 1'b1;
   localparam logic OP_SUB = 1'b0;

   typedef enum logic [1:0] {
      SEL_A_X = 2'b00,
      SEL_A_S = 2'b01,
      SEL_A_H = 2'b10,
      SEL_A_K = 2'b11
   } sel_a_e;

   typedef enum logic [1:0] {
      SEL_B_S  = 2'b00,
      SEL_B_C1 = 2'b01,
      SEL_B_H  = 2'b10,
      SEL_B_C2 = 2'b11
   } sel_b_e;

   // 2'b01 is an alias of pass-through
   typedef enum logic [1:0] {
      SH_PASS = 2'b00,
      SH_SHL  = 2'b10,
      SH_SAR  = 2'b11
   } sh_sel_e;

endpackage

// File: rtl/expr_alu.sv
// Combinational add/subtract with signed-overflow detect and post-shift.
module expr_alu
   import expr_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         op_i,
   input  logic [1:0]   m2_i,
   output logic [W-1:0] shifted_o,
   output logic         ovf_o
);

   logic [W-1:0] sum;

   always_comb begin
      sum       = '0;
      ovf_o     = 1'b0;
      shifted_o = '0;
      if (op_i == OP_ADD) begin
         sum   = a_i + b_i;
         ovf_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end else begin
         sum   = a_i - b_i;
         ovf_o = (a_i[W-1] != b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      // overflow reflects the add/sub only; bits lost by the shift are ignored
      case (sh_sel_e'(m2_i))
         SH_SHL:  shifted_o = {sum[W-2:0], 1'b0};
         SH_SAR:  shifted_o = {sum[W-1], sum[W-1:1]};
         default: shifted_o = sum;
      endcase
   end

endmodule

// File: rtl/expression_datapath.sv
// Expression solver datapath: X/S/H working registers, shared ALU, and a
// valid/ready result register with sticky overflow and overrun flags.
module expression_datapath
   import expr_pkg::*;
#(
   parameter int unsigned  W   = W_DEF,
   parameter logic [W-1:0] K_A = W'(0),
   parameter logic [W-1:0] C1  = W'(1),
   parameter logic [W-1:0] C2  = W'(2)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] x_in,
   input  logic         LX,
   input  logic         LS,
   input  logic         LH,
   input  logic         OP,
   input  logic [1:0]   M0,
   input  logic [1:0]   M1,
   input  logic [1:0]   M2,
   input  logic         completed,
   output logic [W-1:0] result,
   output logic         result_valid,
   input  logic         result_ready,
   output logic         overflow,
   output logic         overrun
);

   logic [W-1:0] x_q, x_d, s_q, s_d, h_q, h_d, result_q, result_d;
   logic         valid_q, valid_d, ovf_q, ovf_d, overrun_q, overrun_d;
   logic [W-1:0] op_a, op_b, alu_val;
   logic         alu_ovf;

   expr_alu #(.W(W)) u_alu (
      .a_i       (op_a),
      .b_i       (op_b),
      .op_i      (OP),
      .m2_i      (M2),
      .shifted_o (alu_val),
      .ovf_o     (alu_ovf)
   );

   // Operand muxes
   always_comb begin
      op_a = x_q;
      op_b = s_q;
      case (sel_a_e'(M0))
         SEL_A_X: op_a = x_q;
         SEL_A_S: op_a = s_q;
         SEL_A_H: op_a = h_q;
         SEL_A_K: op_a = K_A;
         default: op_a = x_q;
      endcase
      case (sel_b_e'(M1))
         SEL_B_S:  op_b = s_q;
         SEL_B_C1: op_b = C1;
         SEL_B_H:  op_b = h_q;
         SEL_B_C2: op_b = C2;
         default:  op_b = s_q;
      endcase
   end

   // Next-state for working registers, flags and result handshake
   always_comb begin
      x_d       = x_q;
      s_d       = s_q;
      h_d       = h_q;
      result_d  = result_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      overrun_d = overrun_q;

      if (LX) x_d = x_in;
      if (LS) s_d = alu_val;
      if (LH) h_d = alu_val;

      if ((LS || LH) && alu_ovf) ovf_d = 1'b1;
      else if (LX)               ovf_d = 1'b0;

      // capture reads s_q, i.e. S before any same-cycle LS write
      if (completed) begin
         result_d = s_q;
         valid_d  = 1'b1;
         if (valid_q && !result_ready)     overrun_d = 1'b1;
         else if (valid_q && result_ready) overrun_d = 1'b0;
      end else if (valid_q && result_ready) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q       <= '0;
         s_q       <= '0;
         h_q       <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         x_q       <= x_d;
         s_q       <= s_d;
         h_q       <= h_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
         overrun_q <= overrun_d;
      end
   end

   assign result       = result_q;
   assign result_valid = valid_q;
   assign overflow     = ovf_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_expression_datapath.sv
// Randomized and directed bench for expression_datapath against an
// integer-arithmetic reference model.
module tb_expression_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] x_in;
   logic        LX, LS, LH, OP;
   logic [1:0]  M0, M1, M2;
   logic        completed, result_ready;
   logic [15:0] result;
   logic        result_valid, overflow, overrun;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [15:0] mx, ms, mh, mres;
   bit          mval, movf, movr;

   expression_datapath dut (
      .clk          (clk),
      .rst          (rst),
      .x_in         (x_in),
      .LX           (LX),
      .LS           (LS),
      .LH           (LH),
      .OP           (OP),
      .M0           (M0),
      .M1           (M1),
      .M2           (M2),
      .completed    (completed),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .overflow     (overflow),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".result"}, 32'(result), 32'(mres));
      check({tag, ".valid"}, 32'(result_valid), 32'(mval));
      check({tag, ".overflow"}, 32'(overflow), 32'(movf));
      check({tag, ".overrun"}, 32'(overrun), 32'(movr));
   endtask

   task automatic model_reset();
      mx = '0; ms = '0; mh = '0; mres = '0;
      mval = 0; movf = 0; movr = 0;
   endtask

   // One clock: drive strobes, advance the model, sample #1 after the edge.
   task automatic cyc(input string tag, input bit lx, input bit ls, input bit lh, input bit op,
                      input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                      input bit comp, input bit rdy, input logic [15:0] xin);
      int a, b, sum, s16;
      logic [15:0] v, wrap;
      bit ov;
      logic [15:0] nx, ns, nh, nres;
      bit nval, novf, novr;
      LX = lx; LS = ls; LH = lh; OP = op; M0 = m0; M1 = m1; M2 = m2;
      completed = comp; result_ready = rdy; x_in = xin;
      case (m0)
         2'd0: a = int'($signed(mx));
         2'd1: a = int'($signed(ms));
         2'd2: a = int'($signed(mh));
         default: a = 0;
      endcase
      case (m1)
         2'd0: b = int'($signed(ms));
         2'd1: b = 1;
         2'd2: b = int'($signed(mh));
         default: b = 2;
      endcase
      sum  = op ? a + b : a - b;
      ov   = (sum > 32767) || (sum < -32768);
      wrap = 16'(sum);
      s16  = int'($signed(wrap));
      case (m2)
         2'd2:    v = 16'(s16 * 2);
         2'd3:    v = 16'(s16 >>> 1);
         default: v = wrap;
      endcase
      nx = lx ? xin : mx;
      ns = ls ? v : ms;
      nh = lh ? v : mh;
      novf = ((ls || lh) && ov) ? 1'b1 : (lx ? 1'b0 : movf);
      nres = mres; nval = mval; novr = movr;
      if (mval && rdy) begin nval = 0; novr = 0; end
      if (comp) begin
         nres = ms; nval = 1;
         if (mval && !rdy) novr = 1;
      end
      @(posedge clk);
      #1;
      mx = nx; ms = ns; mh = nh; mres = nres; mval = nval; movf = novf; movr = novr;
      check_outs(tag);
   endtask

   task automatic idle(input string tag, input bit rdy);
      cyc(tag, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, rdy, 16'd0);
   endtask

   task automatic solver_seq(input int upto);
      cyc("seq_lx", 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 16'd3);
      if (upto > 1) cyc("seq_s1", 0, 1, 0, 1, 2'd0, 2'd1, 2'd0, 0, 0, 16'd0);
      if (upto > 2) cyc("seq_h1", 0, 0, 1, 1, 2'd1, 2'd0, 2'd2, 0, 0, 16'd0);
      if (upto > 3) cyc("seq_s2", 0, 1, 0, 1, 2'd2, 2'd0, 2'd0, 0, 0, 16'd0);
      if (upto > 4) cyc("seq_h2", 0, 0, 1, 0, 2'd2, 2'd3, 2'd2, 0, 0, 16'd0);
      if (upto > 5) cyc("seq_s3", 0, 1, 0, 0, 2'd3, 2'd0, 2'd3, 0, 0, 16'd0);
   endtask

   initial begin
      logic [15:0] held;
      rst = 1'b1; x_in = '0; LX = 0; LS = 0; LH = 0; OP = 0;
      M0 = '0; M1 = '0; M2 = '0; completed = 0; result_ready = 0;
      model_reset();
      #12;
      check_outs("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full sequence yields -10
      solver_seq(6);
      cyc("seq_comp", 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 16'd0);
      check("seq_result", 32'(result), 32'h0000_FFF6);
      check("seq_valid", 32'(result_valid), 32'd1);
      check("seq_ovf", 32'(overflow), 32'd0);

      // Handshake: held stable while not ready
      held = result;
      for (int i = 0; i < 5; i++) begin
         idle("hold", 0);
         check("hold_stable", 32'(result), 32'(held));
      end
      idle("accept", 1);
      check("accept_valid", 32'(result_valid), 32'd0);

      // Overflow: 0x7FFF + 1
      cyc("ovf_lx", 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 16'h7FFF);
      cyc("ovf_add", 0, 1, 0, 1, 2'd0, 2'd1, 2'd0, 0, 0, 16'd0);
      check("ovf_set", 32'(overflow), 32'd1);
      cyc("ovf_comp", 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 16'd0);
      check("ovf_s", 32'(result), 32'h0000_8000);

      // Overrun: second capture while pending; LX also clears overflow
      cyc("ovr_lx", 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 16'h0005);
      check("ovf_clr", 32'(overflow), 32'd0);
      cyc("ovr_ls", 0, 1, 0, 1, 2'd0, 2'd3, 2'd0, 0, 0, 16'd0);
      cyc("ovr_comp", 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 16'd0);
      check("ovr_result", 32'(result), 32'd7);
      check("ovr_flag", 32'(overrun), 32'd1);
      idle("ovr_accept", 1);
      check("ovr_acc_valid", 32'(result_valid), 32'd0);
      check("ovr_acc_flag", 32'(overrun), 32'd0);

      // Simultaneous: LS=LH, then capture S-H while an older result is accepted
      cyc("both_ld", 0, 1, 1, 1, 2'd0, 2'd2, 2'd0, 0, 0, 16'd0);
      cyc("pre_comp", 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 16'd0);
      cyc("s_minus_h", 0, 1, 0, 0, 2'd1, 2'd2, 2'd0, 0, 0, 16'd0);
      cyc("comp_acc", 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 16'd0);
      check("sim_valid", 32'(result_valid), 32'd1);
      check("sim_s_eq_h", 32'(result), 32'd0);
      check("sim_ovr", 32'(overrun), 32'd0);

      // Reset mid-computation, asynchronously between edges
      solver_seq(3);
      #3 rst = 1'b1;
      #1;
      model_reset();
      check_outs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      solver_seq(6);
      cyc("rerun_comp", 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 16'd0);
      check("rerun_result", 32'(result), 32'h0000_FFF6);

      // Randomized strobes against the model
      for (int i = 0; i < 400; i++) begin
         cyc("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0), 1'($urandom), 2'($urandom), 2'($urandom),
             2'($urandom), ($urandom_range(0, 6) == 0), ($urandom_range(0, 2) == 0),
             16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
